otter_lsu: RTL

- Load/store unit directly upstream of the OTTER memory data port (MEM_ADDR2/MEM_DIN2/MEM_WE2/MEM_RDEN2/MEM_SIZE/MEM_SIGN/MEM_DOUT2).
- Takes one load/store request at a time from the core and sequences it into one or more memory-port accesses.
- Returns a sized, sign- or zero-extended load result, or a store completion, plus an error flag.
- Memory natively handles byte at any offset, half at offsets 0–2, word at offset 0 only; everything else is misaligned and is handled by this block.

---
 rtl/otter_lsu_if.sv | 35 +++
 rtl/otter_lsu.sv | 197 +++++++++++++++++++
 2 files changed

// File: rtl/otter_lsu_if.sv
// Core-side request/response and memory data-port signals of the OTTER load/store unit.
// The LSU uses the slave view; the core/memory side uses the master view.
interface otter_lsu_if;
    logic        req_valid;
    logic        req_ready;
    logic        req_we;
    logic [31:0] req_addr;
    logic [31:0] req_wdata;
    logic [1:0]  req_size;
    logic        req_sign;

    logic        rsp_valid;
    logic [31:0] rsp_rdata;
    logic        rsp_err;

    logic        mem_rden2;
    logic        mem_we2;
    logic [31:0] mem_addr2;
    logic [31:0] mem_din2;
    logic [1:0]  mem_size;
    logic        mem_sign;
    logic [31:0] mem_dout2;

    modport slave (
        input  req_valid, req_we, req_addr, req_wdata, req_size, req_sign, mem_dout2,
        output req_ready, rsp_valid, rsp_rdata, rsp_err,
        output mem_rden2, mem_we2, mem_addr2, mem_din2, mem_size, mem_sign
    );

    modport master (
        output req_valid, req_we, req_addr, req_wdata, req_size, req_sign, mem_dout2,
        input  req_ready, rsp_valid, rsp_rdata, rsp_err,
        input  mem_rden2, mem_we2, mem_addr2, mem_din2, mem_size, mem_sign
    );
endinterface

// File: rtl/otter_lsu.sv
// OTTER load/store unit: sequences one request into memory-port accesses.
// Define OTTER_LSU_SPLIT_EN to split misaligned accesses; otherwise they return an error.
module otter_lsu #(
    parameter logic [31:0] MmioBase = 32'h0001_0000
) (
    input  logic       clk_i,
    input  logic       rst_i,
    otter_lsu_if.slave bus
);

`ifdef OTTER_LSU_SPLIT_EN
    typedef enum logic [2:0] {
        StIdle = 3'd0, StAcc = 3'd1, StResp = 3'd2, StRdLo = 3'd3, StRdHi = 3'd4, StWrB = 3'd5
    } state_e;
`else
    typedef enum logic [2:0] {StIdle = 3'd0, StAcc = 3'd1, StResp = 3'd2} state_e;
`endif

    state_e      state_q;
    logic        we_q;
    logic        rsp_valid_q, rsp_err_q;
    logic [31:0] rsp_rdata_q;
    logic        mem_rden2_q, mem_we2_q, mem_sign_q;
    logic [31:0] mem_addr2_q, mem_din2_q;
    logic [1:0]  mem_size_q;

    logic [1:0]  req_off;
    logic        req_misal;
    logic        req_err;

`ifdef OTTER_LSU_SPLIT_EN
    logic [31:0] wdata_q, lo_q;
    logic [1:0]  size_q, off_q, cnt_q;
    logic        sign_q;
    logic [1:0]  req_last_k;
    logic [31:0] req_last;
    logic        req_mmio;
    logic [1:0]  wr_next_k;
    logic [7:0]  wr_next_byte;
    logic [1:0]  wr_last_k;

    // Pick the N bytes starting at byte 'off' of {hi,lo} and extend them.
    function automatic logic [31:0] align_load(logic [63:0] pair, logic [1:0] off,
                                               logic [1:0] size, logic sign);
        logic [31:0] sh;
        sh = 32'(pair >> {off, 3'b000});
        if (size == 2'd1) begin
            return sign ? {16'b0, sh[15:0]} : {{16{sh[15]}}, sh[15:0]};
        end
        return sh;
    endfunction
`endif

    always_comb begin
        req_off   = bus.req_addr[1:0];
        req_misal = (bus.req_size == 2'd1 && req_off == 2'd3) ||
                    (bus.req_size == 2'd2 && req_off != 2'd0);
`ifdef OTTER_LSU_SPLIT_EN
        case (bus.req_size)
            2'd0:    req_last_k = 2'd0;
            2'd1:    req_last_k = 2'd1;
            default: req_last_k = 2'd3;
        endcase
        req_last = bus.req_addr + {30'b0, req_last_k};
        req_mmio = (bus.req_addr >= MmioBase) || (req_last >= MmioBase);
        req_err  = (bus.req_size == 2'd3) || (req_misal && req_mmio);
`else
        req_err  = (bus.req_size == 2'd3) || req_misal;
`endif
    end

`ifdef OTTER_LSU_SPLIT_EN
    always_comb begin
        wr_next_k    = cnt_q + 2'd1;
        wr_next_byte = wdata_q[{wr_next_k, 3'b000} +: 8];
        wr_last_k    = (size_q == 2'd1) ? 2'd1 : 2'd3;
    end
`endif

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q     <= StIdle;
            we_q        <= 1'b0;
            rsp_valid_q <= 1'b0;
            rsp_err_q   <= 1'b0;
            rsp_rdata_q <= 32'b0;
            mem_rden2_q <= 1'b0;
            mem_we2_q   <= 1'b0;
            mem_addr2_q <= 32'b0;
            mem_din2_q  <= 32'b0;
            mem_size_q  <= 2'b0;
            mem_sign_q  <= 1'b0;
`ifdef OTTER_LSU_SPLIT_EN
            wdata_q     <= 32'b0;
            lo_q        <= 32'b0;
            size_q      <= 2'b0;
            off_q       <= 2'b0;
            cnt_q       <= 2'b0;
            sign_q      <= 1'b0;
`endif
        end else begin
            mem_rden2_q <= 1'b0;
            mem_we2_q   <= 1'b0;
            rsp_valid_q <= 1'b0;
            case (state_q)
                StIdle: begin
                    if (bus.req_valid) begin
                        we_q    <= bus.req_we;
`ifdef OTTER_LSU_SPLIT_EN
                        wdata_q <= bus.req_wdata;
                        size_q  <= bus.req_size;
                        sign_q  <= bus.req_sign;
                        off_q   <= req_off;
                        cnt_q   <= 2'd0;
`endif
                        if (req_err) begin
                            rsp_valid_q <= 1'b1;
                            rsp_err_q   <= 1'b1;
                            rsp_rdata_q <= 32'b0;
                            state_q     <= StResp;
`ifdef OTTER_LSU_SPLIT_EN
                        end else if (req_misal && bus.req_we) begin
                            mem_we2_q   <= 1'b1;
                            mem_addr2_q <= bus.req_addr;
                            mem_din2_q  <= {24'b0, bus.req_wdata[7:0]};
                            mem_size_q  <= 2'd0;
                            mem_sign_q  <= bus.req_sign;
                            state_q     <= StWrB;
                        end else if (req_misal) begin
                            mem_rden2_q <= 1'b1;
                            mem_addr2_q <= {bus.req_addr[31:2], 2'b00};
                            mem_size_q  <= 2'd2;
                            mem_sign_q  <= 1'b1;
                            state_q     <= StRdLo;
`endif
                        end else begin
                            mem_rden2_q <= ~bus.req_we;
                            mem_we2_q   <= bus.req_we;
                            mem_addr2_q <= bus.req_addr;
                            mem_din2_q  <= bus.req_wdata;
                            mem_size_q  <= bus.req_size;
                            mem_sign_q  <= bus.req_sign;
                            state_q     <= StAcc;
                        end
                    end
                end
                StAcc: begin
                    rsp_valid_q <= 1'b1;
                    rsp_err_q   <= 1'b0;
                    rsp_rdata_q <= we_q ? 32'b0 : bus.mem_dout2;
                    state_q     <= StResp;
                end
`ifdef OTTER_LSU_SPLIT_EN
                StRdLo: begin
                    lo_q        <= bus.mem_dout2;
                    mem_rden2_q <= 1'b1;
                    mem_addr2_q <= mem_addr2_q + 32'd4;
                    state_q     <= StRdHi;
                end
                StRdHi: begin
                    rsp_valid_q <= 1'b1;
                    rsp_err_q   <= 1'b0;
                    rsp_rdata_q <= align_load({bus.mem_dout2, lo_q}, off_q, size_q, sign_q);
                    state_q     <= StResp;
                end
                StWrB: begin
                    if (cnt_q == wr_last_k) begin
                        rsp_valid_q <= 1'b1;
                        rsp_err_q   <= 1'b0;
                        rsp_rdata_q <= 32'b0;
                        state_q     <= StResp;
                    end else begin
                        cnt_q       <= wr_next_k;
                        mem_we2_q   <= 1'b1;
                        mem_addr2_q <= mem_addr2_q + 32'd1;
                        mem_din2_q  <= {24'b0, wr_next_byte};
                    end
                end
`endif
                StResp:  state_q <= StIdle;
                default: state_q <= StIdle;
            endcase
        end
    end

    assign bus.req_ready = (state_q == StIdle);
    assign bus.rsp_valid = rsp_valid_q;
    assign bus.rsp_err   = rsp_err_q;
    assign bus.rsp_rdata = rsp_rdata_q;
    assign bus.mem_rden2 = mem_rden2_q;
    assign bus.mem_we2   = mem_we2_q;
    assign bus.mem_addr2 = mem_addr2_q;
    assign bus.mem_din2  = mem_din2_q;
    assign bus.mem_size  = mem_size_q;
    assign bus.mem_sign  = mem_sign_q;

endmodule
